// File: rtl/interval_timer.sv
// Memory-mapped interval timer: counts down from PRESET and raises irq on expiry.
// Mode 0 is one-shot with a held level irq; mode 1 auto-reloads with a one-cycle pulse.
module interval_timer #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  state_t           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;

  logic en, im, auto_reload, wr_ctrl, wr_preset;

  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'd1);
  assign im          = ctrl_q[3];
  assign wr_ctrl     = we && (addr == A_CTRL);
  assign wr_preset   = we && (addr == A_PRESET);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    if (wr_ctrl || wr_preset) begin
      pend_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = din[CNT_W-1:0];
    end

    // Expiry sets pend after the bus clear above, so a write in the expiry cycle loses.
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q <= CNT_W'(1)) begin
          count_d = '0;
          pend_d  = 1'b1;
          state_d = ST_INT;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A bus write to CTRL overrides the one-shot EN clear.
    if (wr_ctrl) begin
      ctrl_d = din[3:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      A_CTRL:   dout = {28'b0, ctrl_q};
      A_PRESET: dout = 32'(preset_q);
      A_COUNT:  dout = 32'(count_q);
      default:  dout = '0;
    endcase
  end

  assign irq = pend_q & im;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed and randomized scenarios checked
// against timing rules computed arithmetically from PRESET, mode and write times.
`timescale 1ns/1ps
module tb_interval_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  interval_timer #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Cycles from counting start to expiry.
  function automatic int unsigned run_len(input int unsigned p);
    return (p == 0) ? 1 : p;
  endfunction

  // COUNT value k cycles after the counter was loaded with p.
  function automatic logic [31:0] exp_count(input int unsigned p, input int unsigned k);
    if (k >= p) return 32'd0;
    return 32'(p - k);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
    $display("[%0t] wr addr=%0d data=0x%0h", $time, a, d);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; we = 1'b0; addr = 2'd0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_checks++;
      if (v !== 32'd0) begin n_fail++; $display("FAIL reset_read addr=%0d got=0x%0h want=0", a, v); end
    end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b want=0", irq); end
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd2, 32'h0000_1234);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      n_checks++;
      if (v !== 32'd0) begin n_fail++; $display("FAIL ignored_write addr=%0d got=0x%0h want=0", a, v); end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    logic [1:0]  mode;
    int unsigned p, l, m;
    for (int it = 0; it < 7; it++) begin
      p    = (it == 0) ? 3 : $urandom_range(0, 20);
      m    = (it == 0) ? 0 : $urandom_range(0, 2);
      mode = (m == 0) ? 2'd0 : 2'(m + 1);
      l    = run_len(p);
      wr(2'd1, p);
      wr(2'd0, {28'b0, 1'b1, mode, 1'b1});
      for (int k = 1; k <= int'(l) + 4; k++) begin
        step();
        n_checks++;
        if (irq !== (k >= int'(l) + 2)) begin
          n_fail++; $display("FAIL oneshot_irq p=%0d k=%0d got=%b want=%b", p, k, irq, (k >= int'(l) + 2));
        end
        if (k >= 2) begin
          rd(2'd2, v);
          n_checks++;
          if (v !== exp_count(p, k - 2)) begin
            n_fail++; $display("FAIL oneshot_count p=%0d k=%0d got=%0d want=%0d", p, k, v, exp_count(p, k - 2));
          end
        end
        if (k == int'(l) + 3) begin
          rd(2'd0, v);
          n_checks++;
          if (v !== {28'b0, 1'b1, mode, 1'b0}) begin
            n_fail++; $display("FAIL oneshot_en_clear got=0x%0h want=0x%0h", v, {28'b0, 1'b1, mode, 1'b0});
          end
        end
      end
      if (it % 2 == 1) begin
        wr(2'd1, 32'd5);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL preset_write_clears_pend got=%b want=0", irq); end
      end
      wr(2'd0, 32'd0);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL ctrl_write_clears_irq got=%b want=0", irq); end
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic        im;
    logic        want_irq;
    int unsigned p, l, per, ph, pulses;
    for (int it = 0; it < 4; it++) begin
      p   = (it == 0) ? 2 : $urandom_range(0, 6);
      im  = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      l   = run_len(p);
      per = l + 2;
      pulses = 0;
      wr(2'd1, p);
      wr(2'd0, {28'b0, im, 2'b01, 1'b1});
      for (int k = 1; k <= 2 + 6 * int'(per); k++) begin
        step();
        if (irq === 1'b1) pulses++;
        if (k >= 2) begin
          ph = (k - 2) % per;
          want_irq = im && (ph == l);
          n_checks++;
          if (irq !== want_irq) begin
            n_fail++; $display("FAIL reload_irq p=%0d k=%0d got=%b want=%b", p, k, irq, want_irq);
          end
          rd(2'd2, v);
          n_checks++;
          if (v !== ((ph <= l) ? exp_count(p, ph) : 32'd0)) begin
            n_fail++; $display("FAIL reload_count p=%0d k=%0d got=%0d want=%0d", p, k, v,
                               ((ph <= l) ? exp_count(p, ph) : 32'd0));
          end
        end else begin
          n_checks++;
          if (irq !== 1'b0) begin n_fail++; $display("FAIL reload_irq_early got=%b want=0", irq); end
        end
      end
      n_checks++;
      if (pulses != (im ? 6 : 0)) begin
        n_fail++; $display("FAIL reload_pulse_count p=%0d got=%0d want=%0d", p, pulses, (im ? 6 : 0));
      end
      wr(2'd0, 32'd0);
      repeat (4) step();
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reload_stop_irq got=%b want=0", irq); end
    end
  endtask

  task automatic test_disable_reenable();
    logic [31:0] v;
    int unsigned p, s, l;
    for (int it = 0; it < 3; it++) begin
      p = (it == 0) ? 10 : $urandom_range(5, 16);
      s = (it == 0) ? 6 : $urandom_range(2, p - 1);
      l = run_len(p);
      wr(2'd1, p);
      wr(2'd0, 32'h9);
      for (int k = 1; k <= 2 + int'(p - s); k++) begin
        step();
        if (k >= 2) begin
          rd(2'd2, v);
          n_checks++;
          if (v !== exp_count(p, k - 2)) begin
            n_fail++; $display("FAIL pre_disable_count k=%0d got=%0d want=%0d", k, v, exp_count(p, k - 2));
          end
        end
      end
      wr(2'd0, 32'h8);
      for (int j = 0; j < 5; j++) begin
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'(s - 1) || irq !== 1'b0) begin
          n_fail++; $display("FAIL frozen_count j=%0d got=%0d irq=%b want=%0d irq=0", j, v, irq, s - 1);
        end
        step();
      end
      wr(2'd0, 32'h9);
      for (int k = 1; k <= int'(l) + 4; k++) begin
        step();
        n_checks++;
        if (irq !== (k >= int'(l) + 2)) begin
          n_fail++; $display("FAIL reenable_irq p=%0d k=%0d got=%b want=%b", p, k, irq, (k >= int'(l) + 2));
        end
        if (k >= 2) begin
          rd(2'd2, v);
          n_checks++;
          if (v !== exp_count(p, k - 2)) begin
            n_fail++; $display("FAIL reenable_count k=%0d got=%0d want=%0d", k, v, exp_count(p, k - 2));
          end
        end
      end
      wr(2'd1, p);
    end
  endtask

  task automatic test_preset_midrun();
    logic [31:0] v;
    int unsigned p, q, lq;
    p  = $urandom_range(6, 15);
    q  = $urandom_range(0, 20);
    lq = run_len(q);
    wr(2'd1, p);
    wr(2'd0, 32'h9);
    repeat (4) step();
    wr(2'd1, q);
    for (int k = 5; k <= int'(p) + 3; k++) begin
      rd(2'd2, v);
      n_checks++;
      if (v !== exp_count(p, k - 2) || irq !== (k >= int'(p) + 2)) begin
        n_fail++; $display("FAIL midrun_preset k=%0d count=%0d irq=%b want count=%0d irq=%b",
                           k, v, irq, exp_count(p, k - 2), (k >= int'(p) + 2));
      end
      step();
    end
    rd(2'd1, v);
    n_checks++;
    if (v !== 32'(q)) begin n_fail++; $display("FAIL preset_readback got=%0d want=%0d", v, q); end
    wr(2'd0, 32'h9);
    for (int k = 1; k <= int'(lq) + 3; k++) begin
      step();
      n_checks++;
      if (irq !== (k >= int'(lq) + 2)) begin
        n_fail++; $display("FAIL new_preset_irq q=%0d k=%0d got=%b want=%b", q, k, irq, (k >= int'(lq) + 2));
      end
      if (k >= 2) begin
        rd(2'd2, v);
        n_checks++;
        if (v !== exp_count(q, k - 2)) begin
          n_fail++; $display("FAIL new_preset_count k=%0d got=%0d want=%0d", k, v, exp_count(q, k - 2));
        end
      end
    end
    wr(2'd1, 32'd0);
  endtask

  task automatic test_mask_priority();
    logic [31:0] v;
    int unsigned p, l;
    // Masked expiry, then a CTRL write that sets IM but clears pend.
    p = $urandom_range(0, 12);
    l = run_len(p);
    wr(2'd1, p);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= int'(l) + 4; k++) begin
      step();
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_irq k=%0d got=%b want=0", k, irq); end
    end
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL masked_ctrl got=0x%0h want=0", v); end
    wr(2'd0, 32'h8);
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL unmask_after_clear j=%0d got=%b want=0", j, irq); end
      step();
    end
    // CTRL write landing on the expiry edge: pend survives and IM exposes it at once.
    p = $urandom_range(1, 12);
    l = run_len(p);
    wr(2'd1, p);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= int'(l) + 1; k++) step();
    wr(2'd0, 32'h9);
    rd(2'd0, v);
    n_checks++;
    if (irq !== 1'b1 || v !== 32'h9) begin
      n_fail++; $display("FAIL expiry_write irq=%b ctrl=0x%0h want irq=1 ctrl=0x9", irq, v);
    end
    step();
    rd(2'd0, v);
    n_checks++;
    if (irq !== 1'b1 || v !== 32'h8) begin
      n_fail++; $display("FAIL expiry_write_after irq=%b ctrl=0x%0h want irq=1 ctrl=0x8", irq, v);
    end
    // CTRL write in the INT cycle beats the EN clear and restarts the timer.
    p = $urandom_range(1, 10);
    l = run_len(p);
    wr(2'd1, p);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL preset_clear_pend got=%b want=0", irq); end
    wr(2'd0, 32'h9);
    for (int k = 1; k <= int'(l) + 2; k++) step();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL int_cycle_irq got=%b want=1", irq); end
    wr(2'd0, 32'h9);
    rd(2'd0, v);
    n_checks++;
    if (irq !== 1'b0 || v !== 32'h9) begin
      n_fail++; $display("FAIL int_write_wins irq=%b ctrl=0x%0h want irq=0 ctrl=0x9", irq, v);
    end
    for (int j = 1; j <= int'(l) + 2; j++) begin
      step();
      n_checks++;
      if (irq !== (j >= int'(l) + 2)) begin
        n_fail++; $display("FAIL restart_irq j=%0d got=%b want=%b", j, irq, (j >= int'(l) + 2));
      end
      if (j == 2) begin
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'(p)) begin n_fail++; $display("FAIL restart_count got=%0d want=%0d", v, p); end
      end
    end
    wr(2'd0, 32'd0);
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    int unsigned p, l;
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    repeat (5) step();
    rd(2'd2, v);
    n_checks++;
    if (v !== 32'd7) begin n_fail++; $display("FAIL pre_reset_count got=%0d want=7", v); end
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      n_checks++;
      if (v !== 32'd0) begin n_fail++; $display("FAIL async_reset_read addr=%0d got=0x%0h want=0", a, v); end
    end
    for (int j = 0; j < 20; j++) begin
      step();
      rd(2'd2, v);
      n_checks++;
      if (irq !== 1'b0 || v !== 32'd0) begin
        n_fail++; $display("FAIL post_reset j=%0d irq=%b count=%0d want irq=0 count=0", j, irq, v);
      end
    end
    p = $urandom_range(0, 5);
    l = run_len(p);
    wr(2'd1, p);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= int'(l) + 3; k++) step();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL held_irq_before_reset got=%b want=1", irq); end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL async_irq_drop got=%b want=0", irq); end
    reset = 1'b0;
    rd(2'd0, v);
    n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL async_reset_ctrl got=0x%0h want=0", v); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_disable_reenable();
    test_preset_midrun();
    test_mask_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
